bv_match_fifo: RTL and testbench

- Terminal stage of the bv_count shift/count pipeline.
- Consumes the last stage's bv_out_valid/bv_out/count_out and resolves each lookup into a hit flag plus matched rule index.
- Results are buffered in a small synchronous FIFO and presented to the action/lookup consumer over a valid/ready handshake.
- The bv_count chain cannot stall, so this block absorbs backpressure. It warns upstream with almost_full and accounts for dropped results.

---
 rtl/bv_match_fifo_pkg.sv | 11 +
 rtl/bv_match_fifo_if.sv | 23 ++
 rtl/bv_sync_fifo.sv | 60 ++++++
 rtl/bv_match_fifo.sv | 93 +++++++++
 tb/tb_bv_match_fifo.sv | 178 +++++++++++++++++
 5 files changed

// File: rtl/bv_match_fifo_pkg.sv
// Shared constants for the bv_count pipeline and its match/result FIFO.
// Default widths here must track the bv_count chain.
package bv_match_fifo_pkg;

    localparam int DEF_WIDTH       = 64;
    localparam int DEF_WIDTH_COUNT = 6;
    localparam int DROP_W          = 16;

    localparam logic [DROP_W-1:0] DROP_SAT = 16'hFFFF;

endpackage

// File: rtl/bv_match_fifo_if.sv
// Result handshake between the match FIFO and the action/lookup consumer.
interface bv_match_if #(
    parameter int width_count = 6
);
    logic                   result_valid;
    logic                   result_ready;
    logic                   result_hit;
    logic [width_count-1:0] result_index;

    modport master (
        output result_valid,
        output result_hit,
        output result_index,
        input  result_ready
    );

    modport slave (
        input  result_valid,
        input  result_hit,
        input  result_index,
        output result_ready
    );
endinterface

// File: rtl/bv_sync_fifo.sv
// Show-ahead synchronous FIFO with occupancy counter.
// A push into a full FIFO is only taken when a pop frees the slot in the same cycle.
module bv_sync_fifo #(
    parameter int dw         = 7,
    parameter int depth      = 4,
    parameter int addr_width = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                push,
    input  logic                pop,
    input  logic [dw-1:0]       wdata,
    output logic [dw-1:0]       rdata,
    output logic [addr_width:0] occupancy,
    output logic                full,
    output logic                empty
);

    localparam logic [addr_width:0] FULL_OCC = (addr_width+1)'(depth);

    logic [dw-1:0]         mem [depth];
    logic [addr_width-1:0] wr_ptr;
    logic [addr_width-1:0] rd_ptr;
    logic                  wr_en;
    logic                  rd_en;

    assign full  = (occupancy == FULL_OCC);
    assign empty = (occupancy == '0);
    assign rd_en = pop & ~empty;
    assign wr_en = push & (~full | rd_en);
    assign rdata = mem[rd_ptr];

    // Storage carries no reset; only the pointers define what is live.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occupancy <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (wr_en && !rd_en) begin
                occupancy <= occupancy + 1'b1;
            end else if (!wr_en && rd_en) begin
                occupancy <= occupancy - 1'b1;
            end
        end
    end

endmodule

// File: rtl/bv_match_fifo.sv
// Terminal bv_count stage: resolves hit/index and buffers results,
// absorbing consumer backpressure since the chain cannot stall.
module bv_match_fifo
    import bv_match_fifo_pkg::*;
#(
    parameter int width       = DEF_WIDTH,
    parameter int width_count = DEF_WIDTH_COUNT,
    parameter int depth       = 4,
    parameter int addr_width  = 2,
    parameter int af_level    = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   bv_valid,
    input  logic [width-1:0]       bv,
    input  logic [width_count-1:0] count,
    bv_match_if.master             res,
    output logic                   almost_full,
    output logic                   overflow,
    output logic [DROP_W-1:0]      drop_count
);

    localparam int DW = width_count + 1;
    localparam logic [addr_width:0] AF_OCC = (addr_width+1)'(af_level);

    logic                   hit;
    logic [width_count-1:0] index;
    logic [DW-1:0]          head;
    logic [addr_width:0]    occupancy;
    logic [addr_width:0]    occ_next;
    logic                   full;
    logic                   empty;
    logic                   pop;
    logic                   accept;
    logic                   drop;
    logic                   unused_bv;

    // Only the LSB of the shifted vector decides a match.
    assign hit       = bv[0];
    assign index     = hit ? count : '0;
    assign unused_bv = &{1'b0, bv[width-1:1]};

    assign pop    = ~empty & res.result_ready;
    assign accept = bv_valid & (~full | pop);
    assign drop   = bv_valid & full & ~pop;

    bv_sync_fifo #(
        .dw         (DW),
        .depth      (depth),
        .addr_width (addr_width)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (bv_valid),
        .pop       (pop),
        .wdata     ({hit, index}),
        .rdata     (head),
        .occupancy (occupancy),
        .full      (full),
        .empty     (empty)
    );

    assign res.result_valid = ~empty;
    assign res.result_hit   = ~empty & head[DW-1];
    assign res.result_index = empty ? '0 : head[width_count-1:0];

    always_comb begin
        occ_next = occupancy;
        if (accept && !pop) begin
            occ_next = occupancy + 1'b1;
        end else if (!accept && pop) begin
            occ_next = occupancy - 1'b1;
        end
    end

    // almost_full follows next-state occupancy so it moves with result_valid.
    always_ff @(posedge clk) begin
        if (reset) begin
            almost_full <= 1'b0;
            overflow    <= 1'b0;
            drop_count  <= '0;
        end else begin
            almost_full <= (occ_next >= AF_OCC);
            if (drop) begin
                overflow <= 1'b1;
                if (drop_count != DROP_SAT) begin
                    drop_count <= drop_count + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_bv_match_fifo.sv
// Scoreboard bench for bv_match_fifo: directed pushes, monitor-checked pops.
module tb_bv_match_fifo;

    logic        clk = 1'b0;
    logic        reset;
    logic        bv_valid;
    logic [63:0] bv;
    logic [5:0]  count;
    logic        almost_full;
    logic        overflow;
    logic [15:0] drop_count;

    int n_cmp = 0;
    int n_bad = 0;

    logic [6:0] exp_q[$];

    bv_match_if #(.width_count(6)) res ();

    bv_match_fifo dut (
        .clk         (clk),
        .reset       (reset),
        .bv_valid    (bv_valid),
        .bv          (bv),
        .count       (count),
        .res         (res),
        .almost_full (almost_full),
        .overflow    (overflow),
        .drop_count  (drop_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [63:0] v, input logic [5:0] c,
                         input bit queued);
        bv_valid = 1'b1;
        bv       = v;
        count    = c;
        if (queued) exp_q.push_back({v[0], v[0] ? c : 6'd0});
        tick();
        bv_valid = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!reset && res.result_valid && res.result_ready) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL pop_unexpected: got %0h want none",
                         {res.result_hit, res.result_index});
            end else begin
                chk("pop_data", {25'd0, res.result_hit, res.result_index},
                    {25'd0, exp_q.pop_front()});
            end
        end
    end

    initial begin
        reset = 1'b1;
        bv_valid = 1'b0;
        bv = '0;
        count = '0;
        res.result_ready = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        chk("rst_valid", {31'd0, res.result_valid}, 0);
        chk("rst_af", {31'd0, almost_full}, 0);
        chk("rst_ovf", {31'd0, overflow}, 0);
        chk("rst_drop", {16'd0, drop_count}, 0);
        chk("rst_hit_idx", {25'd0, res.result_hit, res.result_index}, 0);

        // single hit, consumer idle, data must hold
        drive(64'h0000_0000_0000_0001, 6'd13, 1'b1);
        for (int i = 0; i < 5; i++) begin
            chk("hold_valid", {31'd0, res.result_valid}, 1);
            chk("hold_data", {25'd0, res.result_hit, res.result_index},
                {25'd0, 1'b1, 6'd13});
            tick();
        end
        res.result_ready = 1'b1;
        tick();
        res.result_ready = 1'b0;
        chk("hit_drained", {31'd0, res.result_valid}, 0);

        // miss
        drive(64'h0, 6'd63, 1'b1);
        chk("miss_valid", {31'd0, res.result_valid}, 1);
        chk("miss_data", {25'd0, res.result_hit, res.result_index}, 0);
        res.result_ready = 1'b1;
        tick();
        res.result_ready = 1'b0;

        // fill and overflow
        drive(64'hA5A5_0000_0000_0003, 6'd1, 1'b1);
        chk("af_after1", {31'd0, almost_full}, 0);
        drive(64'hA5A5_0000_0000_0003, 6'd2, 1'b1);
        chk("af_after2", {31'd0, almost_full}, 1);
        drive(64'h8000_0000_0000_0001, 6'd3, 1'b1);
        drive(64'h8000_0000_0000_0001, 6'd4, 1'b1);
        chk("full_ovf0", {31'd0, overflow}, 0);
        drive(64'h1, 6'd5, 1'b0);
        chk("ovf_set", {31'd0, overflow}, 1);
        chk("drop_one", {16'd0, drop_count}, 1);
        res.result_ready = 1'b1;
        repeat (4) tick();
        res.result_ready = 1'b0;
        chk("fill_drained", {31'd0, res.result_valid}, 0);
        chk("fill_af_clr", {31'd0, almost_full}, 0);

        // push and pop together while full
        for (int i = 11; i <= 14; i++) drive(64'h1, 6'(i), 1'b1);
        res.result_ready = 1'b1;
        drive(64'h1, 6'd9, 1'b1);
        chk("pp_af", {31'd0, almost_full}, 1);
        chk("pp_drop", {16'd0, drop_count}, 1);
        repeat (4) tick();
        chk("pp_drained", {31'd0, res.result_valid}, 0);

        // continuous streaming across pointer wrap
        for (int i = 0; i < 20; i++) begin
            bv_valid = 1'b1;
            bv = 64'h1;
            count = 6'(i);
            exp_q.push_back({1'b1, 6'(i)});
            tick();
            chk("stream_af", {31'd0, almost_full}, 0);
        end
        bv_valid = 1'b0;
        tick();
        res.result_ready = 1'b0;
        chk("stream_empty", {31'd0, res.result_valid}, 0);
        chk("stream_drop", {16'd0, drop_count}, 1);

        // reset mid-operation
        for (int i = 20; i < 23; i++) drive(64'h1, 6'(i), 1'b1);
        chk("pre_rst_ovf", {31'd0, overflow}, 1);
        reset = 1'b1;
        exp_q.delete();
        tick();
        reset = 1'b0;
        chk("mid_rst_valid", {31'd0, res.result_valid}, 0);
        chk("mid_rst_af", {31'd0, almost_full}, 0);
        chk("mid_rst_ovf", {31'd0, overflow}, 0);
        chk("mid_rst_drop", {16'd0, drop_count}, 0);
        drive(64'h1, 6'd7, 1'b1);
        res.result_ready = 1'b1;
        tick();
        res.result_ready = 1'b0;
        tick();
        chk("post_rst_empty", {31'd0, res.result_valid}, 0);
        chk("queue_left", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got hang want finish");
        $fatal(1);
    end

endmodule
